rsa_result_capture: RTL

- Downstream consumer of the exponentiate core (c = m^e mod n).
- Arms on the start pulse, counts clock cycles until the core reports ready, and latches the RSA_WIDTH-bit result.
- Presents status, cycle count and result as DATA_WIDTH-bit words to the AXI-lite read mux.
- The cycle count is the per-key timing measurement the host reads back.

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/rsa_result_capture.sv | 109 ++++++++++
 2 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA result capture block: readout word map,
// status bit positions and FSM state encoding.
package rsa_pkg;

  localparam int WORD_STATUS  = 0;
  localparam int WORD_CYCLES  = 1;
  localparam int WORD_RESULT0 = 2;

  localparam int BUSY = 0;
  localparam int DONE = 1;
  localparam int TMO  = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_TMO
  } state_t;

endpackage

// File: rtl/rsa_result_capture.sv
// Measures exponentiate-core run time from start to core_ready, latches the result,
// and serves status/cycles/result words to the read mux with one cycle of read latency.
module rsa_result_capture
  import rsa_pkg::*;
#(
  parameter int unsigned RSA_WIDTH      = 128,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned ARM_DELAY      = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  core_ready,
  input  logic [RSA_WIDTH-1:0]  core_c,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_word,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  done_pulse,
  output logic [DATA_WIDTH-1:0] cycles
);

  localparam int unsigned NW = RSA_WIDTH / DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ARM_LIMIT = DATA_WIDTH'(ARM_DELAY);
  localparam logic [DATA_WIDTH-1:0] TMO_LAST  = DATA_WIDTH'(TIMEOUT_CYCLES - 32'd1);
  localparam logic                  TMO_EN    = (TIMEOUT_CYCLES != 32'd0);

  state_t                  state;
  logic [RSA_WIDTH-1:0]    result;
  logic                    complete;
  logic                    tmo_hit;
  logic [DATA_WIDTH-1:0]   cycles_next;
  logic [DATA_WIDTH-1:0]   rd_mux;

  // Ready seen inside the arm window is a leftover from the previous run.
  always_comb begin
    complete    = core_ready && (cycles >= ARM_LIMIT);
    tmo_hit     = TMO_EN && (cycles == TMO_LAST) && !complete;
    cycles_next = (cycles == {DATA_WIDTH{1'b1}}) ? cycles : cycles + 1'b1;
  end

  always_comb begin
    rd_mux = '0;
    if (rd_word == ADDR_W'(WORD_STATUS)) begin
      rd_mux[BUSY] = busy;
      rd_mux[DONE] = done;
      rd_mux[TMO]  = timeout;
    end else if (rd_word == ADDR_W'(WORD_CYCLES)) begin
      rd_mux = cycles;
    end else begin
      for (int i = 0; i < int'(NW); i++) begin
        if (rd_word == ADDR_W'(WORD_RESULT0 + i))
          rd_mux = result[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      done_pulse <= 1'b0;
      cycles     <= '0;
      result     <= '0;
      rd_data    <= '0;
    end else begin
      done_pulse <= 1'b0;
      if (start) begin
        state   <= S_RUN;
        busy    <= 1'b1;
        done    <= 1'b0;
        timeout <= 1'b0;
        cycles  <= '0;
        result  <= '0;
      end else begin
        case (state)
          S_RUN: begin
            if (complete) begin
              result     <= core_c;
              done       <= 1'b1;
              done_pulse <= 1'b1;
              busy       <= 1'b0;
              state      <= S_DONE;
            end else begin
              cycles <= cycles_next;
              if (tmo_hit) begin
                timeout    <= 1'b1;
                done_pulse <= 1'b1;
                busy       <= 1'b0;
                state      <= S_TMO;
              end
            end
          end
          default: ;
        endcase
      end
      // Mux sees pre-update registers, so a read on the capture cycle returns old values.
      if (rd_en)
        rd_data <= rd_mux;
    end
  end

endmodule
